pulse_seq_gen: RTL and testbench

Registered bipolar pulse-train generator driving the transducer pulser outputs (positive, negative, damp). It is the transmit-side counterpart of the input glitch filtering: every output edge comes from a flop, every high or low phase lasts at least one full clock period, and positive and negative drive are never asserted together. It sits between the acquisition-control FSM, which issues `start` with a latched configuration, and the pulser pins.

---
 rtl/pulse_seq_pkg.sv | 21 ++
 rtl/pulse_seq_gen_phase_timer.sv | 23 ++
 rtl/pulse_seq_gen.sv | 139 +++++++++++++
 tb/tb_pulse_seq_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the bipolar pulse-train generator.
package pulse_seq_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int NPULSE_W_DEF = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POS   = 3'd1,
    DEAD1 = 3'd2,
    NEG   = 3'd3,
    DEAD2 = 3'd4,
    DAMP  = 3'd5
  } pseq_state_t;

  // A zero length would mean a phase that never ends; treat it as one cycle.
  function automatic logic [31:0] clamp1(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_seq_gen_phase_timer.sv
// Loadable down-counter timing the current phase; shared by every phase
// because only one phase is ever active.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  // Load (len-1) on phase entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               value <= '0;
    else if (load)         value <= load_val;
    else if (value != '0)  value <= value - 1'b1;
  end

  assign expired = (value == '0);

endmodule

// File: rtl/pulse_seq_gen.sv
// Registered bipolar pulse-train generator (positive / negative / damp).
// All pin drives come straight from flops fed by the next-state decode, so
// no pin can glitch and positive/negative drive are mutually exclusive.
module pulse_seq_gen
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NPULSE_W = NPULSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_on_len,
  input  logic [CNT_W-1:0]    cfg_dead_len,
  input  logic [NPULSE_W-1:0] cfg_npulses,
  input  logic [CNT_W-1:0]    cfg_damp_len,
  output logic                out_p,
  output logic                out_n,
  output logic                out_damp,
  output logic                busy,
  output logic                done
);

  pseq_state_t         state, nxt;
  logic [CNT_W-1:0]    on_m1, dead_m1, damp_m1;
  logic [NPULSE_W-1:0] pcnt;
  logic                abort_q, abort_eff;
  logic                tim_ld, tim_exp;
  logic [CNT_W-1:0]    tim_ld_val, tim_val;
  logic [CNT_W-1:0]    on_m1_in, dead_m1_in, damp_m1_in;
  logic [NPULSE_W-1:0] np_m1_in;

  // Clamped (len-1) values of the live config, used only at start.
  assign on_m1_in   = CNT_W'(clamp1(32'(cfg_on_len))   - 32'd1);
  assign dead_m1_in = CNT_W'(clamp1(32'(cfg_dead_len)) - 32'd1);
  assign damp_m1_in = CNT_W'(clamp1(32'(cfg_damp_len)) - 32'd1);
  assign np_m1_in   = NPULSE_W'(clamp1(32'(cfg_npulses)) - 32'd1);

  // Abort is a level but must be remembered until the dead phase drains.
  assign abort_eff = abort | abort_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tim_ld),
    .load_val (tim_ld_val),
    .value    (tim_val),
    .expired  (tim_exp)
  );

  // Next-state decode and timer load for the phase being entered.
  always_comb begin
    nxt        = state;
    tim_ld     = 1'b0;
    tim_ld_val = '0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt = POS; tim_ld = 1'b1; tim_ld_val = on_m1_in;
        end else if (tim_val != '0) begin
          // Keep the shared counter parked at zero while idle.
          tim_ld = 1'b1;
        end
      end
      POS: begin
        // Abort from drive goes through the full dead time before damping.
        if (abort_eff) begin
          nxt = DEAD2; tim_ld = 1'b1; tim_ld_val = dead_m1;
        end else if (tim_exp) begin
          nxt = DEAD1; tim_ld = 1'b1; tim_ld_val = dead_m1;
        end
      end
      DEAD1: begin
        if (tim_exp) begin
          if (abort_eff) begin
            nxt = DAMP; tim_ld = 1'b1; tim_ld_val = damp_m1;
          end else begin
            nxt = NEG;  tim_ld = 1'b1; tim_ld_val = on_m1;
          end
        end
      end
      NEG: begin
        if (abort_eff || tim_exp) begin
          nxt = DEAD2; tim_ld = 1'b1; tim_ld_val = dead_m1;
        end
      end
      DEAD2: begin
        if (tim_exp) begin
          if (abort_eff || pcnt == '0) begin
            nxt = DAMP; tim_ld = 1'b1; tim_ld_val = damp_m1;
          end else begin
            nxt = POS;  tim_ld = 1'b1; tim_ld_val = on_m1;
          end
        end
      end
      DAMP: begin
        if (tim_exp) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, latched config, pulse count and registered pin drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      on_m1    <= '0;
      dead_m1  <= '0;
      damp_m1  <= '0;
      pcnt     <= '0;
      abort_q  <= 1'b0;
      out_p    <= 1'b0;
      out_n    <= 1'b0;
      out_damp <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      out_p    <= (nxt == POS);
      out_n    <= (nxt == NEG);
      out_damp <= (nxt == DAMP);
      busy     <= (nxt != IDLE);
      done     <= (state != IDLE) && (nxt == IDLE);
      if (state == IDLE && start) begin
        on_m1   <= on_m1_in;
        dead_m1 <= dead_m1_in;
        damp_m1 <= damp_m1_in;
        pcnt    <= np_m1_in;
      end else if (state == DEAD2 && nxt == POS) begin
        pcnt <= pcnt - 1'b1;
      end
      // Abort seen on the start cycle itself is not captured.
      if (nxt == IDLE)                 abort_q <= 1'b0;
      else if (state != IDLE && abort) abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Directed bench for pulse_seq_gen: hand-timed waveforms, abort, reset,
// start-while-busy, then a random run with pin-safety invariants.
module tb_pulse_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] cfg_on_len, cfg_dead_len, cfg_damp_len;
  logic [5:0] cfg_npulses;
  logic       out_p, out_n, out_damp, busy, done;

  int checks   = 0;
  int failures = 0;

  pulse_seq_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_on_len   (cfg_on_len),
    .cfg_dead_len (cfg_dead_len),
    .cfg_npulses  (cfg_npulses),
    .cfg_damp_len (cfg_damp_len),
    .out_p        (out_p),
    .out_n        (out_n),
    .out_damp     (out_damp),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] on, input logic [7:0] dd,
                         input logic [5:0] np, input logic [7:0] dm);
    cfg_on_len = on; cfg_dead_len = dd; cfg_npulses = np; cfg_damp_len = dm;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin step(); n++; end
    chk("wait_idle", {7'd0, busy}, 8'd0);
  endtask

  function automatic logic [7:0] pins();
    return {3'd0, out_p, out_n, out_damp, busy, done};
  endfunction

  // on=3 dead=2 npulses=2 damp=4; cycle 1 is the first cycle after start
  // is sampled.
  function automatic logic [7:0] exp_t1(int i);
    logic p, n, d, b, dn;
    p  = (i >= 1 && i <= 3) || (i >= 11 && i <= 13);
    n  = (i >= 6 && i <= 8) || (i >= 16 && i <= 18);
    d  = (i >= 21 && i <= 24);
    b  = (i >= 1 && i <= 24);
    dn = (i == 25);
    return {3'd0, p, n, d, b, dn};
  endfunction

  // on=dead=damp=npulses=0, all clamped to 1.
  function automatic logic [7:0] exp_zero(int i);
    logic p, n, d, b, dn;
    p = (i == 1); n = (i == 3); d = (i == 5);
    b = (i >= 1 && i <= 5); dn = (i == 6);
    return {3'd0, p, n, d, b, dn};
  endfunction

  // on=5 dead=3 damp=2, abort during the 2nd POS cycle.
  function automatic logic [7:0] exp_abort(int i);
    logic p, d, b, dn;
    p = (i == 1 || i == 2); d = (i == 6 || i == 7);
    b = (i >= 1 && i <= 7); dn = (i == 8);
    return {3'd0, p, 1'b0, d, b, dn};
  endfunction

  initial begin
    logic pp, pn;
    int   busy_cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(8'd0, 8'd0, 6'd0, 8'd0);
    #1;
    chk("reset_pins", pins(), 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_after_reset", pins(), 8'h00);

    // Undisturbed reference run.
    set_cfg(8'd3, 8'd2, 6'd2, 8'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 27; i++) begin
      chk($sformatf("base_c%0d", i), pins(), exp_t1(i));
      if (busy) busy_cnt++;
      step();
    end
    chk("base_busy_len", 8'(busy_cnt), 8'd24);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    step(); step();
    chk("abort_idle", pins(), 8'h00);

    // Start and abort together: start wins and the one-cycle abort is dropped.
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      chk($sformatf("start_abort_c%0d", i), pins(), exp_t1(i));
      step();
    end

    // Start re-pulsed and cfg changed mid-run; relaunch from the done cycle.
    set_cfg(8'd3, 8'd2, 6'd2, 8'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      chk($sformatf("disturb_c%0d", i), pins(), exp_t1(i));
      if (i == 5) begin start = 1'b1; set_cfg(8'd9, 8'd0, 6'd5, 8'd1); end
      if (i == 6) start = 1'b0;
      if (i == 25) begin start = 1'b1; set_cfg(8'd2, 8'd1, 6'd1, 8'd1); end
      step();
    end
    start = 1'b0;
    chk("relaunch", pins(), 8'b0001_0010);
    wait_idle(50);
    step();

    // All-zero config clamps to one-cycle phases.
    set_cfg(8'd0, 8'd0, 6'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("zero_c%0d", i), pins(), exp_zero(i));
      step();
    end

    // Abort on the 2nd POS cycle.
    set_cfg(8'd5, 8'd3, 6'd3, 8'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("abort_c%0d", i), pins(), exp_abort(i));
      abort = (i == 2);
      step();
    end
    abort = 1'b0;

    // Asynchronous reset mid-NEG.
    set_cfg(8'd3, 8'd2, 6'd2, 8'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 7; i++) step();
    chk("pre_rst_neg", pins(), 8'b0000_1010);
    #2 rst = 1'b1;
    #1 chk("async_rst", pins(), 8'h00);
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("post_rst_idle", pins(), 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start", pins(), 8'b0001_0010);
    wait_idle(50);

    // Random run: pins mutually exclusive, dead gap between polarities,
    // no drive while idle, done only when idle.
    pp = 1'b0; pn = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      set_cfg(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
              6'($urandom_range(0, 2)), 8'($urandom_range(0, 3)));
      step();
      chk("rnd_onehot", 8'(32'(out_p) + 32'(out_n) + 32'(out_damp) <= 1), 8'd1);
      chk("rnd_gap_pn", {7'd0, out_p & pn}, 8'd0);
      chk("rnd_gap_np", {7'd0, out_n & pp}, 8'd0);
      chk("rnd_idle_quiet", {7'd0, ~busy & (out_p | out_n | out_damp)}, 8'd0);
      chk("rnd_done_idle", {7'd0, done & busy}, 8'd0);
      pp = out_p; pn = out_n;
    end
    start = 1'b0; abort = 1'b0;
    wait_idle(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
